// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle between one initiator and one target.
// Clock and reset stay outside the bundle on the connected modules.
interface axi4_lite_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction, one response out.
// Zero-wait slave gives rsp_valid in the 4th cycle counting the accept cycle; rsp_ready stalls the next command.
module axi4_lite_master #(
  parameter int         ADDR_W = 16,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [15:0]       err_count,
  axi4_lite_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t state, state_nxt;
  logic   run_q;
  logic   aw_pend, w_pend, aw_pend_nxt, w_pend_nxt;
  logic   cmd_fire, aw_hs, w_hs, b_hs, ar_hs, r_hs, resp_err;

  // run_q holds cmd_ready low until the first edge after reset release
  assign cmd_ready = run_q && (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign b_hs      = axi.bvalid && axi.bready;
  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_hs      = axi.rvalid && axi.rready;
  assign resp_err  = (b_hs && (axi.bresp != 2'b00)) || (r_hs && (axi.rresp != 2'b00));

  assign axi.awvalid = aw_pend;
  assign axi.wvalid  = w_pend;
  assign axi.arvalid = (state == RD_ADDR);
  assign axi.bready  = (state == WRESP);
  assign axi.rready  = (state == RD_DATA);
  assign axi.awprot  = PROT;
  assign axi.arprot  = PROT;
  assign rsp_valid   = (state == RESP);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_write) begin
            state_nxt   = WR;
            aw_pend_nxt = 1'b1;
            w_pend_nxt  = 1'b1;
          end else begin
            state_nxt = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W retire independently; leave once both are gone
        if (aw_hs) aw_pend_nxt = 1'b0;
        if (w_hs)  w_pend_nxt  = 1'b0;
        if (!aw_pend_nxt && !w_pend_nxt) state_nxt = WRESP;
      end
      WRESP:   if (b_hs)      state_nxt = RESP;
      RD_ADDR: if (ar_hs)     state_nxt = RD_DATA;
      RD_DATA: if (r_hs)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q      <= 1'b0;
      axi.awaddr <= '0;
      axi.araddr <= '0;
      axi.wdata  <= '0;
      axi.wstrb  <= '0;
      rsp_rdata  <= '0;
      rsp_resp   <= 2'b00;
      err_count  <= 16'd0;
    end else begin
      run_q <= 1'b1;
      if (cmd_fire) begin
        if (cmd_write) begin
          axi.awaddr <= cmd_addr;
          axi.wdata  <= cmd_wdata;
          axi.wstrb  <= cmd_wstrb;
        end else begin
          axi.araddr <= cmd_addr;
        end
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= axi.bresp;
      end
      if (r_hs) begin
        rsp_rdata <= axi.rdata;
        rsp_resp  <= axi.rresp;
      end
      if (resp_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench: the initial block plays command source, response sink and AXI4-Lite slave.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_axi4_lite_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;

  axi4_lite_master_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  axi4_lite_master #(.ADDR_W(16), .DATA_W(32), .PROT(3'b000)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .err_count (err_count),
    .axi       (bus.master)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 16'h0;
    cmd_wdata   = 32'h0;
    cmd_wstrb   = 4'h0;
    rsp_ready   = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;

    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_awvalid",   {31'd0, bus.awvalid}, 32'd0);
    check("rst_arvalid",   {31'd0, bus.arvalid}, 32'd0);
    check("rst_bready",    {31'd0, bus.bready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_awaddr",    {16'd0, bus.awaddr}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    tick();
    aresetn = 1'b1;
    check("rel_cmd_ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // T1: zero-wait write
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 16'h1234;
    cmd_wdata   = 32'hDEADBEEF;
    cmd_wstrb   = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("t1_awvalid_c1", {31'd0, bus.awvalid}, 32'd1);
    check("t1_wvalid_c1",  {31'd0, bus.wvalid}, 32'd1);
    check("t1_awaddr",     {16'd0, bus.awaddr}, 32'h1234);
    check("t1_wdata",      bus.wdata, 32'hDEADBEEF);
    check("t1_wstrb",      {28'd0, bus.wstrb}, 32'hF);
    check("t1_awprot",     {29'd0, bus.awprot}, 32'd0);
    check("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    tick();
    check("t1_awvalid_c2", {31'd0, bus.awvalid}, 32'd0);
    check("t1_wvalid_c2",  {31'd0, bus.wvalid}, 32'd0);
    check("t1_bready_c2",  {31'd0, bus.bready}, 32'd1);
    check("t1_rsp_valid_c2", {31'd0, rsp_valid}, 32'd0);
    tick();
    bus.bvalid = 1'b0;
    check("t1_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    check("t1_bready_c3",    {31'd0, bus.bready}, 32'd0);
    check("t1_rsp_resp",     {30'd0, rsp_resp}, 32'd0);
    check("t1_rsp_rdata",    rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
    check("t1_cmd_ready_done", {31'd0, cmd_ready}, 32'd1);

    // T2: W handshake three cycles ahead of AW
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 16'h0200;
    cmd_wdata   = 32'h01020304;
    cmd_wstrb   = 4'h3;
    tick();
    cmd_valid = 1'b0;
    check("t2_awvalid_c1", {31'd0, bus.awvalid}, 32'd1);
    check("t2_wvalid_c1",  {31'd0, bus.wvalid}, 32'd1);
    tick();
    bus.wready = 1'b0;
    check("t2_wvalid_c2",  {31'd0, bus.wvalid}, 32'd0);
    check("t2_awvalid_c2", {31'd0, bus.awvalid}, 32'd1);
    tick();
    check("t2_awvalid_c3", {31'd0, bus.awvalid}, 32'd1);
    check("t2_awaddr_c3",  {16'd0, bus.awaddr}, 32'h0200);
    tick();
    check("t2_awvalid_c4", {31'd0, bus.awvalid}, 32'd1);
    check("t2_bready_c4",  {31'd0, bus.bready}, 32'd0);
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    check("t2_awvalid_c5", {31'd0, bus.awvalid}, 32'd0);
    check("t2_bready_c5",  {31'd0, bus.bready}, 32'd1);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t2_bready_c6", {31'd0, bus.bready}, 32'd0);
    check("t2_rsp_resp",  {30'd0, rsp_resp}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // T3: read with arready held off for 5 cycles
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0040;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_arvalid_wait", {31'd0, bus.arvalid}, 32'd1);
      check("t3_araddr_wait",  {16'd0, bus.araddr}, 32'h0040);
      check("t3_arprot",       {29'd0, bus.arprot}, 32'd0);
      tick();
    end
    check("t3_arvalid_c6", {31'd0, bus.arvalid}, 32'd1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    check("t3_arvalid_c7", {31'd0, bus.arvalid}, 32'd0);
    check("t3_rready_c7",  {31'd0, bus.rready}, 32'd1);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hCAFEF00D;
    bus.rresp  = 2'b00;
    tick();
    bus.rvalid = 1'b0;
    check("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t3_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    check("t3_rsp_resp",  {30'd0, rsp_resp}, 32'd0);
    check("t3_err_count", {16'd0, err_count}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // T4a: read answered with SLVERR
    bus.arready = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = 16'h0044;
    tick();
    cmd_valid = 1'b0;
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h5555AAAA;
    bus.rresp   = 2'b10;
    tick();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    check("t4_rd_rsp_resp",  {30'd0, rsp_resp}, 32'h2);
    check("t4_rd_rsp_rdata", rsp_rdata, 32'h5555AAAA);
    check("t4_rd_err_count", {16'd0, err_count}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // T4b: write answered with DECERR
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 16'h0048;
    cmd_wdata   = 32'h0BADF00D;
    cmd_wstrb   = 4'h1;
    tick();
    cmd_valid = 1'b0;
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b11;
    tick();
    tick();
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
    check("t4_wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t4_wr_rsp_resp",  {30'd0, rsp_resp}, 32'h3);
    check("t4_wr_rsp_rdata", rsp_rdata, 32'd0);
    check("t4_wr_err_count", {16'd0, err_count}, 32'd2);

    // T5: response stalled 10 cycles with a command waiting
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      check("t5_cmd_ready_stall", {31'd0, cmd_ready}, 32'd0);
      check("t5_rsp_valid_stall", {31'd0, rsp_valid}, 32'd1);
      check("t5_rsp_resp_stall",  {30'd0, rsp_resp}, 32'h3);
      check("t5_rsp_rdata_stall", rsp_rdata, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t5_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
    check("t5_rsp_valid_next", {31'd0, rsp_valid}, 32'd0);
    bus.arready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t5_arvalid",  {31'd0, bus.arvalid}, 32'd1);
    check("t5_araddr",   {16'd0, bus.araddr}, 32'h0100);
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h00000011;
    tick();
    bus.rvalid = 1'b0;
    check("t5_rsp_rdata", rsp_rdata, 32'h11);
    check("t5_err_count", {16'd0, err_count}, 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // T6: asynchronous reset while AW is outstanding
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 16'h0300;
    cmd_wdata   = 32'h12345678;
    cmd_wstrb   = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("t6_awvalid_pre", {31'd0, bus.awvalid}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_awvalid_async", {31'd0, bus.awvalid}, 32'd0);
    check("t6_wvalid_async",  {31'd0, bus.wvalid}, 32'd0);
    check("t6_cmd_ready_rst", {31'd0, cmd_ready}, 32'd0);
    check("t6_rsp_valid_rst", {31'd0, rsp_valid}, 32'd0);
    check("t6_err_count_rst", {16'd0, err_count}, 32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check("t6_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    check("t6_awvalid_idle",   {31'd0, bus.awvalid}, 32'd0);
    tick();
    check("t6_rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
    check("t6_err_count_idle", {16'd0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
